// File: rtl/huff_sym_counter.sv
// Per-symbol histogram front-end for the Huffman code builder.
// Optional sticky out-of-range flag on sym_err when HUFF_SYM_ERR_EN is defined.
module huff_sym_counter #(
  parameter int NUM_SAMPLES = 100,
  parameter int SYM_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_valid,
  input  logic [SYM_W-1:0] gray_data,
  output logic             busy,
  output logic             CNT_valid,
  output logic [7:0]       CNT1,
  output logic [7:0]       CNT2,
  output logic [7:0]       CNT3,
  output logic [7:0]       CNT4,
  output logic [7:0]       CNT5,
  output logic [7:0]       CNT6
`ifdef HUFF_SYM_ERR_EN
  ,
  output logic             sym_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

  state_t     state_q, state_d;
  logic [7:0] sample_q, sample_d;
  logic [7:0] cnt_q [6];
  logic [7:0] cnt_d [6];
  logic       in_range;

`ifdef HUFF_SYM_ERR_EN
  logic err_q, err_d;
`endif

  assign in_range = (gray_data >= SYM_W'(1)) && (gray_data <= SYM_W'(6));

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
`ifdef HUFF_SYM_ERR_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gray_valid) begin
          // First sample restarts the histogram: clear and seed in one step.
          for (int i = 0; i < 6; i++) begin
            cnt_d[i] = (gray_data == SYM_W'(i + 1)) ? 8'd1 : 8'd0;
          end
          sample_d = 8'd1;
`ifdef HUFF_SYM_ERR_EN
          err_d    = !in_range;
`endif
          state_d  = (NUM_SAMPLES == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (gray_valid) begin
          for (int i = 0; i < 6; i++) begin
            if (gray_data == SYM_W'(i + 1)) cnt_d[i] = cnt_q[i] + 8'd1;
          end
          sample_d = sample_q + 8'd1;
`ifdef HUFF_SYM_ERR_EN
          err_d    = err_q | !in_range;
`endif
          if (sample_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
`ifdef HUFF_SYM_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
`ifdef HUFF_SYM_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign busy      = (state_q == ACC);
  assign CNT_valid = (state_q == DONE);
  assign CNT1      = cnt_q[0];
  assign CNT2      = cnt_q[1];
  assign CNT3      = cnt_q[2];
  assign CNT4      = cnt_q[3];
  assign CNT5      = cnt_q[4];
  assign CNT6      = cnt_q[5];
`ifdef HUFF_SYM_ERR_EN
  assign sym_err   = err_q;
`endif

endmodule

// File: tb/tb_huff_sym_counter.sv
// Directed bench for huff_sym_counter (NUM_SAMPLES = 100); checks sym_err when HUFF_SYM_ERR_EN is defined.
module tb_huff_sym_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_valid;
  logic [7:0] gray_data;
  logic       busy, CNT_valid;
  logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
`ifdef HUFF_SYM_ERR_EN
  logic       sym_err;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [7:0] cnt_w [6];
  logic [7:0] exp_c [6];

  huff_sym_counter #(.NUM_SAMPLES(100), .SYM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_valid(gray_valid),
    .gray_data (gray_data),
    .busy      (busy),
    .CNT_valid (CNT_valid),
    .CNT1      (CNT1),
    .CNT2      (CNT2),
    .CNT3      (CNT3),
    .CNT4      (CNT4),
    .CNT5      (CNT5),
    .CNT6      (CNT6)
`ifdef HUFF_SYM_ERR_EN
    ,
    .sym_err   (sym_err)
`endif
  );

  always #5 clk = ~clk;

  assign cnt_w[0] = CNT1;
  assign cnt_w[1] = CNT2;
  assign cnt_w[2] = CNT3;
  assign cnt_w[3] = CNT4;
  assign cnt_w[4] = CNT5;
  assign cnt_w[5] = CNT6;

  // Counts CNT_valid pulses, sampled mid-cycle.
  always @(negedge clk) if (CNT_valid === 1'b1) pulses++;

  // Drive one cycle of input; returns 1 time unit after the capturing edge.
  task automatic send(input logic v, input logic [7:0] d);
    gray_valid = v;
    gray_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; gray_valid = 1'b0; gray_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || CNT_valid !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl busy=%b valid=%b exp=0/0", busy, CNT_valid);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0) begin
        failures++; $display("FAIL reset_cnt%0d got=%0d exp=0", i + 1, cnt_w[i]);
      end
    end
`ifdef HUFF_SYM_ERR_EN
    checks++;
    if (sym_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sym_err); end
`endif
  endtask

  task automatic test_contiguous();
    int early = 0;
    int p0 = pulses;
    for (int i = 0; i < 99; i++) begin
      send(1'b1, 8'((i % 6) + 1));
      if (CNT_valid !== 1'b0) early++;
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL contig_busy got=%b exp=1", busy); end
      end
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL contig_early got=%0d exp=0", early); end
    send(1'b1, 8'((99 % 6) + 1));
    checks++;
    if (CNT_valid !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL contig_done valid=%b busy=%b exp=1/0", CNT_valid, busy);
    end
    exp_c = '{8'd17, 8'd17, 8'd17, 8'd17, 8'd16, 8'd16};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== exp_c[i]) begin
        failures++; $display("FAIL contig_cnt%0d got=%0d exp=%0d", i + 1, cnt_w[i], exp_c[i]);
      end
    end
    gray_valid = 1'b0;
    send(1'b0, 8'd0);
    checks++;
    if (CNT_valid !== 1'b0 || (pulses - p0) != 1) begin
      failures++; $display("FAIL contig_pulse valid=%b pulses=%0d exp=0/1", CNT_valid, pulses - p0);
    end
  endtask

  task automatic test_toggle();
    int early = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 8'((i % 6) + 1));
      if (i == 99) break;
      if (CNT_valid !== 1'b0) early++;
      send(1'b0, 8'd4);
      if (CNT_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL toggle_early got=%0d exp=0", early); end
    checks++;
    if (CNT_valid !== 1'b1) begin failures++; $display("FAIL toggle_done got=%b exp=1", CNT_valid); end
    exp_c = '{8'd17, 8'd17, 8'd17, 8'd17, 8'd16, 8'd16};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== exp_c[i]) begin
        failures++; $display("FAIL toggle_cnt%0d got=%0d exp=%0d", i + 1, cnt_w[i], exp_c[i]);
      end
    end
    send(1'b0, 8'd0);
  endtask

  task automatic test_two_frames();
    for (int i = 0; i < 100; i++) send(1'b1, 8'd3);
    checks++;
    if (CNT_valid !== 1'b1 || CNT3 !== 8'd100) begin
      failures++; $display("FAIL frameA valid=%b cnt3=%0d exp=1/100", CNT_valid, CNT3);
    end
    send(1'b0, 8'd0);
    send(1'b0, 8'd0);
    checks++;
    if (CNT3 !== 8'd100 || busy !== 1'b0) begin
      failures++; $display("FAIL gap_hold cnt3=%0d busy=%b exp=100/0", CNT3, busy);
    end
    send(1'b1, 8'd1);
    checks++;
    if (CNT3 !== 8'd0 || CNT1 !== 8'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL frameB_first cnt3=%0d cnt1=%0d busy=%b exp=0/1/1", CNT3, CNT1, busy);
    end
    for (int i = 0; i < 49; i++) send(1'b1, 8'd1);
    for (int i = 0; i < 50; i++) send(1'b1, 8'd6);
    checks++;
    if (CNT_valid !== 1'b1) begin failures++; $display("FAIL frameB_done got=%b exp=1", CNT_valid); end
    exp_c = '{8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== exp_c[i]) begin
        failures++; $display("FAIL frameB_cnt%0d got=%0d exp=%0d", i + 1, cnt_w[i], exp_c[i]);
      end
    end
    send(1'b0, 8'd0);
  endtask

  task automatic test_reset_mid();
    int p0 = pulses;
    for (int i = 0; i < 40; i++) send(1'b1, 8'd4);
    reset = 1'b1;
    send(1'b1, 8'd4);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || CNT_valid !== 1'b0 || CNT4 !== 8'd0) begin
      failures++; $display("FAIL midrst busy=%b valid=%b cnt4=%0d exp=0/0/0", busy, CNT_valid, CNT4);
    end
    send(1'b0, 8'd0);
    for (int i = 0; i < 100; i++) send(1'b1, 8'd2);
    checks++;
    if (CNT_valid !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b exp=1", CNT_valid); end
    exp_c = '{8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== exp_c[i]) begin
        failures++; $display("FAIL midrst_cnt%0d got=%0d exp=%0d", i + 1, cnt_w[i], exp_c[i]);
      end
    end
    send(1'b0, 8'd0);
    checks++;
    if ((pulses - p0) != 1) begin failures++; $display("FAIL midrst_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 49; i++) send(1'b1, 8'd5);
    send(1'b1, 8'd0);
    for (int i = 0; i < 49; i++) send(1'b1, 8'd5);
    checks++;
    if (CNT_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL oor_99 valid=%b busy=%b exp=0/1", CNT_valid, busy);
    end
    send(1'b1, 8'd9);
    checks++;
    if (CNT_valid !== 1'b1) begin failures++; $display("FAIL oor_done got=%b exp=1", CNT_valid); end
    exp_c = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd98, 8'd0};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_w[i] !== exp_c[i]) begin
        failures++; $display("FAIL oor_cnt%0d got=%0d exp=%0d", i + 1, cnt_w[i], exp_c[i]);
      end
    end
`ifdef HUFF_SYM_ERR_EN
    checks++;
    if (sym_err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", sym_err); end
`endif
    send(1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) send(1'b1, 8'd1);
    checks++;
    if (CNT_valid !== 1'b1 || CNT1 !== 8'd100) begin
      failures++; $display("FAIL b2b_A valid=%b cnt1=%0d exp=1/100", CNT_valid, CNT1);
    end
    send(1'b1, 8'd6);
    checks++;
    if (busy !== 1'b0 || CNT_valid !== 1'b0 || CNT6 !== 8'd0 || CNT1 !== 8'd100) begin
      failures++; $display("FAIL b2b_drop busy=%b valid=%b cnt6=%0d cnt1=%0d exp=0/0/0/100",
                           busy, CNT_valid, CNT6, CNT1);
    end
    send(1'b1, 8'd2);
    checks++;
    if (busy !== 1'b1 || CNT1 !== 8'd0 || CNT2 !== 8'd1) begin
      failures++; $display("FAIL b2b_start busy=%b cnt1=%0d cnt2=%0d exp=1/0/1", busy, CNT1, CNT2);
    end
`ifdef HUFF_SYM_ERR_EN
    checks++;
    if (sym_err !== 1'b0) begin failures++; $display("FAIL b2b_errclr got=%b exp=0", sym_err); end
`endif
    for (int i = 0; i < 98; i++) send(1'b1, 8'd2);
    checks++;
    if (CNT_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", CNT_valid); end
    send(1'b1, 8'd2);
    checks++;
    if (CNT_valid !== 1'b1 || CNT2 !== 8'd100 || CNT6 !== 8'd0) begin
      failures++; $display("FAIL b2b_B valid=%b cnt2=%0d cnt6=%0d exp=1/100/0", CNT_valid, CNT2, CNT6);
    end
    send(1'b0, 8'd0);
  endtask

  initial begin
    reset = 1'b1; gray_valid = 1'b0; gray_data = 8'd0;
    test_reset();
    test_contiguous();
    test_toggle();
    test_two_frames();
    test_reset_mid();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
